// File: rtl/keypad_key_decoder.sv
// keypad_key_decoder: turns each new keypad press into a 4-bit key code and
// queues the codes in a first-word-fall-through FIFO read over valid/ready.
// Optional build macro: KEYPAD_AUTOREPEAT_EN adds hold-to-repeat pushes.
module keypad_key_decoder #(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned REPEAT_DELAY = 500,
   parameter int unsigned REPEAT_RATE  = 100
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    keypad_col_in,
   input  logic [3:0]                    keypad_row_in,
   input  logic                          key_pressed_in,
   output logic [3:0]                    key_code,
   output logic                          key_valid,
   input  logic                          key_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          overflow_clr,
   output logic                          invalid_key
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_HELD = 1'b1;

   // Reject unusable parameter sets at elaboration
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
      $error("keypad_key_decoder: invalid parameter set");
   end

   logic [0:0]    state_q, state_d;
   logic          key_pressed_d;
   logic [3:0]    last_code_q, last_code_d;
   logic          press;
   logic          enc_ok;
   logic [1:0]    row_idx, col_idx;
   logic [3:0]    decoded;
   logic          push_req;
   logic [3:0]    push_data;
   logic          invalid_d;

   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, next_rd;
   logic [CW-1:0] count_d;
   logic          pop, full, push_ok, drop;
   logic [3:0]    head_d;

   assign press = key_pressed_in & ~key_pressed_d;

   // Row/column one-hot check and matrix position to key code
   always_comb begin
      row_idx = '0;
      col_idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (keypad_row_in[i]) row_idx = 2'(i);
         if (keypad_col_in[i]) col_idx = 2'(i);
      end
      enc_ok = $onehot(keypad_row_in) && $onehot(keypad_col_in);
      case ({row_idx, col_idx})
         4'h0: decoded = 4'h1;  4'h1: decoded = 4'h2;
         4'h2: decoded = 4'h3;  4'h3: decoded = 4'hA;
         4'h4: decoded = 4'h4;  4'h5: decoded = 4'h5;
         4'h6: decoded = 4'h6;  4'h7: decoded = 4'hB;
         4'h8: decoded = 4'h7;  4'h9: decoded = 4'h8;
         4'hA: decoded = 4'h9;  4'hB: decoded = 4'hC;
         4'hC: decoded = 4'hE;  4'hD: decoded = 4'h0;
         4'hE: decoded = 4'hF;  default: decoded = 4'hD;
      endcase
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW   = $clog2(RMAX) + 1;

   logic [RW-1:0] rpt_cnt_q;
   logic          rpt_first_q;
   logic          rpt_hit;

   assign rpt_hit = (state_q == S_HELD) &&
                    (rpt_cnt_q == (rpt_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));

   // Repeat timer: idle outside HELD, first period is the delay, then the rate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b1;
      end else if (state_q != S_HELD || !key_pressed_in) begin
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b1;
      end else if (rpt_hit) begin
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b0;
      end else begin
         rpt_cnt_q   <= rpt_cnt_q + RW'(1);
      end
   end
`endif

   // Press FSM: next state, push request and invalid-encoding flag
   always_comb begin
      state_d     = state_q;
      last_code_d = last_code_q;
      push_req    = 1'b0;
      push_data   = last_code_q;
      invalid_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press) begin
               if (enc_ok) begin
                  state_d     = S_HELD;
                  push_req    = 1'b1;
                  push_data   = decoded;
                  last_code_d = decoded;
               end else begin
                  invalid_d   = 1'b1;
               end
            end
         end
         S_HELD: begin
            if (!key_pressed_in) begin
               state_d = S_IDLE;
`ifdef KEYPAD_AUTOREPEAT_EN
            end else if (rpt_hit) begin
               push_req = 1'b1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state, press-edge history and last accepted code
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         key_pressed_d <= 1'b1;
         last_code_q   <= '0;
         invalid_key   <= 1'b0;
      end else begin
         state_q       <= state_d;
         key_pressed_d <= key_pressed_in;
         last_code_q   <= last_code_d;
         invalid_key   <= invalid_d;
      end
   end

   // FIFO control: pop/push qualification, next count and next head value
   always_comb begin
      pop     = key_valid & key_ready;
      full    = (fifo_count == CW'(FIFO_DEPTH));
      push_ok = push_req & (~full | pop);
      drop    = push_req & full & ~pop;
      next_rd = pop ? rd_ptr + AW'(1) : rd_ptr;
      case ({push_ok, pop})
         2'b10:   count_d = fifo_count + CW'(1);
         2'b01:   count_d = fifo_count - CW'(1);
         default: count_d = fifo_count;
      endcase
      // Bypass when the pushed code lands straight at the head
      head_d = (push_ok && wr_ptr == next_rd) ? push_data : mem[next_rd];
   end

   // FIFO storage array
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // FIFO pointers, registered head/valid/count and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         key_valid  <= 1'b0;
         key_code   <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr     <= next_rd;
         fifo_count <= count_d;
         key_valid  <= (count_d != '0);
         if (count_d != '0) key_code <= head_d;
         if (drop)              overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_key_decoder.sv
// tb_keypad_key_decoder: directed scenarios plus randomized traffic, each
// cycle compared against a queue-based reference model of the decoder.
module tb_keypad_key_decoder;

   localparam int DEPTH = 8;
   localparam int DLY   = 10;
   localparam int RATE  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] keypad_col_in, keypad_row_in;
   logic       key_pressed_in;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic [$clog2(DEPTH):0] fifo_count;
   logic       overflow;
   logic       overflow_clr;
   logic       invalid_key;

   always #5 clk = ~clk;

   keypad_key_decoder #(
      .FIFO_DEPTH  (DEPTH),
      .REPEAT_DELAY(DLY),
      .REPEAT_RATE (RATE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .keypad_col_in (keypad_col_in),
      .keypad_row_in (keypad_row_in),
      .key_pressed_in(key_pressed_in),
      .key_code      (key_code),
      .key_valid     (key_valid),
      .key_ready     (key_ready),
      .fifo_count    (fifo_count),
      .overflow      (overflow),
      .overflow_clr  (overflow_clr),
      .invalid_key   (invalid_key)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
   int q[$];
   bit m_prev, m_held, m_ovf, m_inv;
   int m_since, m_code;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic void model_reset();
      q.delete();
      m_prev = 1'b1;
      m_held = 1'b0;
      m_ovf  = 1'b0;
      m_inv  = 1'b0;
      m_since = 0;
   endfunction

   // One clock edge of the specified behaviour, using the inputs present at the edge
   function automatic void model_edge();
      bit pop, press, push, drop;
      int r, c, code;
      pop   = (q.size() > 0) && key_ready;
      press = key_pressed_in && !m_prev;
      push  = 1'b0;
      drop  = 1'b0;
      code  = 0;
      m_inv = 1'b0;
      if (m_held) begin
         if (!key_pressed_in) m_held = 1'b0;
         else begin
            m_since++;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_since == DLY || (m_since > DLY && (m_since - DLY) % RATE == 0)) begin
               push = 1'b1;
               code = m_code;
            end
`endif
         end
      end else if (press) begin
         r = oh_idx(keypad_row_in);
         c = oh_idx(keypad_col_in);
         if (r >= 0 && c >= 0) begin
            m_held  = 1'b1;
            m_since = 0;
            m_code  = keymap[r*4 + c];
            push    = 1'b1;
            code    = m_code;
         end else begin
            m_inv = 1'b1;
         end
      end
      m_prev = key_pressed_in;
      if (pop) void'(q.pop_front());
      if (push) begin
         if (q.size() < DEPTH) q.push_back(code);
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
   endfunction

   task automatic compare_all();
      check("valid", int'(key_valid), int'(q.size() > 0));
      check("count", int'(fifo_count), q.size());
      if (q.size() > 0) check("code", int'(key_code), q[0]);
      check("overflow", int'(overflow), int'(m_ovf));
      check("invalid", int'(invalid_key), int'(m_inv));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic set_in(input logic p, input logic [3:0] row, input logic [3:0] col,
                         input logic rdy, input logic clr);
      key_pressed_in = p;
      keypad_row_in  = row;
      keypad_col_in  = col;
      key_ready      = rdy;
      overflow_clr   = clr;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      model_reset();
      check("rst_valid", int'(key_valid), 0);
      check("rst_count", int'(fifo_count), 0);
      check("rst_code", int'(key_code), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_invalid", int'(invalid_key), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Press key at (row,col) for one cycle then release for one cycle
   task automatic tap(input logic [3:0] row, input logic [3:0] col, input logic rdy);
      set_in(1'b1, row, col, rdy, 1'b0);
      step();
      set_in(1'b0, row, col, rdy, 1'b0);
      step();
   endtask

   task automatic drain();
      set_in(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) step();
      check("drained", int'(fifo_count), 0);
   endtask

   int peak, exp_pushes;
   int exp3 [4] = '{14, 0, 15, 13};
   logic [3:0] rr, cc;

   initial begin
      // 1: key held across reset release is never reported
      set_in(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 50; i++) step();
      check("t1_no_valid", int'(key_valid), 0);

      // 2: '8' press, valid next cycle, single pop drains
      set_in(1'b0, 4'b0100, 4'b0010, 1'b0, 1'b0);
      step();
      set_in(1'b1, 4'b0100, 4'b0010, 1'b0, 1'b0);
      step();
      check("t2_valid", int'(key_valid), 1);
      check("t2_code", int'(key_code), 8);
      set_in(1'b1, 4'b0100, 4'b0010, 1'b1, 1'b0);
      step();
      check("t2_drained", int'(fifo_count), 0);
      set_in(1'b0, 4'b0100, 4'b0010, 1'b0, 1'b0);
      step();

      // 3: bottom row * 0 # D queued then popped in order
      peak = 0;
      for (int c = 0; c < 4; c++) begin
         cc = 4'b0001 << c;
         tap(4'b1000, cc, 1'b0);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      check("t3_peak", peak, 4);
      set_in(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("t3_order", int'(key_code), exp3[i]);
         step();
      end
      check("t3_empty", int'(fifo_count), 0);

      // 4: overflow on 9th press, clear, then push+pop at full
      for (int i = 0; i < 9; i++) tap(4'b0001, 4'b0001, 1'b0);
      check("t4_full", int'(fifo_count), DEPTH);
      check("t4_overflow", int'(overflow), 1);
      set_in(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1);
      step();
      check("t4_clr", int'(overflow), 0);
      set_in(1'b1, 4'b0010, 4'b0001, 1'b1, 1'b0);
      step();
      check("t4_pushpop_count", int'(fifo_count), DEPTH);
      check("t4_pushpop_ovf", int'(overflow), 0);
      drain();

      // 5: non-one-hot row yields an invalid pulse and no push
      tap(4'b0110, 4'b0001, 1'b0);
      check("t5_count", int'(fifo_count), 0);
      step();
      check("t5_pulse_end", int'(invalid_key), 0);

      // 6: key '5' held for 30 cycles
      set_in(1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) step();
      set_in(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0);
      step();
      step();
`ifdef KEYPAD_AUTOREPEAT_EN
      exp_pushes = 6;
`else
      exp_pushes = 1;
`endif
      check("t6_pushes", int'(fifo_count), exp_pushes);
      check("t6_code", int'(key_code), 5);
      drain();

      // Randomized traffic with occasional mid-run reset
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) key_pressed_in = ~key_pressed_in;
         if ($urandom_range(0, 5) == 0) begin
            rr = 4'($urandom_range(0, 15));
            cc = 4'($urandom_range(0, 15));
         end else begin
            rr = 4'b0001 << $urandom_range(0, 3);
            cc = 4'b0001 << $urandom_range(0, 3);
         end
         keypad_row_in = rr;
         keypad_col_in = cc;
         key_ready     = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
         overflow_clr  = ($urandom_range(0, 19) == 0);
         step();
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
